// File: rtl/lives_pkg.sv
// Shared definitions for the player's life bookkeeping: the state encoding,
// the width of the life count and the default limits used by the HUD and game controller.
package lives_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        GRACE     = 2'd2,
        GAME_OVER = 2'd3
    } lives_state_t;

    localparam int LIVES_W            = 4;
    localparam int DEFAULT_MAX_LIVES  = 9;
    localparam int DEFAULT_INIT_LIVES = 3;

endpackage

// File: rtl/frame_countdown.sv
// Loadable down-counter stepped once per video frame; done flags the step
// that is about to take the count from 1 to 0.
module frame_countdown #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             step,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (step && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Combinational so the owner can leave its timed state on the same edge the count expires.
    assign done = step && (cnt == CNT_W'(1));

endmodule

// File: rtl/lives_manager.sv
// Owns the life count: game start / loss / 1-up events, post-loss grace window
// with HUD blink, respawn request and game-over flag.
module lives_manager
    import lives_pkg::*;
#(
    parameter int INIT_LIVES   = DEFAULT_INIT_LIVES,
    parameter int MAX_LIVES    = DEFAULT_MAX_LIVES,
    parameter int GRACE_FRAMES = 90,
    parameter int BLINK_FRAMES = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               startGame,
    input  logic               lifeLost,
    input  logic               lifeGained,
    output logic [LIVES_W-1:0] lives,
    output logic               gameOver,
    output logic               graceActive,
    output logic               livesBlink,
    output logic               respawnReq
);

    localparam logic [LIVES_W-1:0] INIT_L  = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0] MAX_L   = LIVES_W'(MAX_LIVES);
    localparam logic [7:0]         GRACE_L = 8'(GRACE_FRAMES);
    localparam logic [7:0]         BLINK_L = 8'(BLINK_FRAMES);

    function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] v);
        return (v >= MAX_L) ? MAX_L : v + 1'b1;
    endfunction

    function automatic logic [LIVES_W-1:0] sat_dec(input logic [LIVES_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    lives_state_t       state, state_d;
    logic [LIVES_W-1:0] lives_d;
    logic               blink_d, respawn_d;
    logic [7:0]         bcnt, bcnt_d;
    logic               cd_load, cd_done;
    logic [7:0]         cd_val;

    frame_countdown #(.CNT_W(8)) u_grace_timer (
        .clk      (clk),
        .resetN   (resetN),
        .load     (cd_load),
        .load_val (cd_val),
        .step     (startOfFrame && (state == GRACE)),
        .done     (cd_done)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= IDLE;
            lives      <= INIT_L;
            livesBlink <= 1'b0;
            respawnReq <= 1'b0;
            bcnt       <= '0;
        end else begin
            state      <= state_d;
            lives      <= lives_d;
            livesBlink <= blink_d;
            respawnReq <= respawn_d;
            bcnt       <= bcnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        lives_d   = lives;
        blink_d   = livesBlink;
        bcnt_d    = bcnt;
        respawn_d = 1'b0;
        cd_load   = 1'b0;
        cd_val    = GRACE_L;

        if (startGame) begin
            // A restart wins over any same-cycle loss or 1-up, in every state.
            state_d   = PLAY;
            lives_d   = INIT_L;
            respawn_d = 1'b1;
            cd_load   = 1'b1;
            cd_val    = '0;
            blink_d   = 1'b0;
            bcnt_d    = '0;
        end else begin
            unique case (state)
                IDLE: ;
                PLAY: begin
                    if (lifeLost && (lifeGained || lives > LIVES_W'(1))) begin
                        if (!lifeGained) lives_d = sat_dec(lives);
                        state_d   = GRACE;
                        respawn_d = 1'b1;
                        cd_load   = 1'b1;
                        blink_d   = 1'b1;
                        bcnt_d    = '0;
                    end else if (lifeLost) begin
                        lives_d = '0;
                        state_d = GAME_OVER;
                    end else if (lifeGained) begin
                        lives_d = sat_inc(lives);
                    end
                end
                GRACE: begin
                    if (lifeGained) lives_d = sat_inc(lives);
                    if (cd_done) begin
                        state_d = PLAY;
                        blink_d = 1'b0;
                        bcnt_d  = '0;
                    end else if (startOfFrame) begin
                        if (bcnt == BLINK_L - 8'd1) begin
                            blink_d = ~livesBlink;
                            bcnt_d  = '0;
                        end else begin
                            bcnt_d = bcnt + 8'd1;
                        end
                    end
                end
                GAME_OVER: lives_d = '0;
                default:   state_d = IDLE;
            endcase
        end
    end

    assign gameOver    = (state == GAME_OVER);
    assign graceActive = (state == GRACE);

endmodule

// File: tb/tb_lives_manager.sv
// Directed bench for lives_manager: a vector table for single-cycle behaviour
// plus frame-by-frame sequences for grace timing, game over and mid-grace reset.
module tb_lives_manager;

    logic       clk = 1'b0;
    logic       resetN, startOfFrame, startGame, lifeLost, lifeGained;
    logic [3:0] lives;
    logic       gameOver, graceActive, livesBlink, respawnReq;

    int checks = 0;
    int errors = 0;

    lives_manager dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .startGame    (startGame),
        .lifeLost     (lifeLost),
        .lifeGained   (lifeGained),
        .lives        (lives),
        .gameOver     (gameOver),
        .graceActive  (graceActive),
        .livesBlink   (livesBlink),
        .respawnReq   (respawnReq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sg, ll, lg, sof;
        logic [3:0] lives;
        logic       go, gr, resp, blink;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic sg, ll, lg, sof, input logic [3:0] lv,
                                input logic go, gr, resp, blink);
        vec_t v;
        v.sg = sg; v.ll = ll; v.lg = lg; v.sof = sof;
        v.lives = lv; v.go = go; v.gr = gr; v.resp = resp; v.blink = blink;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] lv, input logic go, gr, resp, blink);
        chk({tag, ".lives"}, int'(lives), int'(lv));
        chk({tag, ".gameOver"}, int'(gameOver), int'(go));
        chk({tag, ".graceActive"}, int'(graceActive), int'(gr));
        chk({tag, ".respawnReq"}, int'(respawnReq), int'(resp));
        chk({tag, ".livesBlink"}, int'(livesBlink), int'(blink));
    endtask

    task automatic drive(input logic sg, ll, lg, sof);
        startGame = sg; lifeLost = ll; lifeGained = lg; startOfFrame = sof;
        @(posedge clk);
        #1;
        startGame = 1'b0; lifeLost = 1'b0; lifeGained = 1'b0; startOfFrame = 1'b0;
    endtask

    // Runs `frames` frame pulses inside grace with a quiet cycle after each;
    // optionally fires a (to be ignored) lifeLost after frame lost_at.
    task automatic run_grace(input string tag, input int frames, input int lost_at,
                             input logic [3:0] lv);
        for (int k = 1; k <= frames; k++) begin
            logic gr_e, bl_e;
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            gr_e = (k < 90);
            bl_e = gr_e && (((k / 8) % 2) == 0);
            chk($sformatf("%s.f%0d.grace", tag, k), int'(graceActive), int'(gr_e));
            chk($sformatf("%s.f%0d.blink", tag, k), int'(livesBlink), int'(bl_e));
            if (k == lost_at) begin
                drive(1'b0, 1'b1, 1'b0, 1'b0);
                chk_all($sformatf("%s.lostInGrace", tag), lv, 1'b0, 1'b1, 1'b0, bl_e);
            end else begin
                drive(1'b0, 1'b0, 1'b0, 1'b0);
                chk($sformatf("%s.f%0d.lives", tag, k), int'(lives), int'(lv));
                chk($sformatf("%s.f%0d.resp", tag, k), int'(respawnReq), 0);
            end
        end
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0; startGame = 1'b0; lifeLost = 1'b0; lifeGained = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all("reset", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        resetN = 1'b1;

        // IDLE ignores loss and 1-up
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("idle.lost", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("idle.gain", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        vecs[0]  = mk(1, 0, 0, 0, 4'd3, 0, 0, 1, 0);  // start
        vecs[1]  = mk(0, 0, 0, 1, 4'd3, 0, 0, 0, 0);  // frame in PLAY
        vecs[2]  = mk(0, 0, 1, 0, 4'd4, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 4'd5, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 1, 0, 4'd5, 0, 1, 1, 1);  // lost+gained -> grace, no change
        vecs[5]  = mk(0, 1, 0, 0, 4'd5, 0, 1, 0, 1);  // loss ignored in grace
        vecs[6]  = mk(0, 0, 1, 0, 4'd6, 0, 1, 0, 1);  // 1-up honoured in grace
        vecs[7]  = mk(1, 1, 1, 0, 4'd3, 0, 0, 1, 0);  // restart wins
        vecs[8]  = mk(0, 1, 0, 1, 4'd2, 0, 1, 1, 1);  // loss with coincident frame
        vecs[9]  = mk(1, 1, 0, 0, 4'd3, 0, 0, 1, 0);  // restart over loss at lives=2
        vecs[10] = mk(0, 0, 1, 0, 4'd4, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 1, 0, 4'd5, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 1, 0, 4'd6, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 1, 0, 4'd7, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 1, 0, 4'd8, 0, 0, 0, 0);
        vecs[15] = mk(0, 0, 1, 0, 4'd9, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 1, 0, 4'd9, 0, 0, 0, 0);  // saturated
        vecs[17] = mk(0, 1, 1, 0, 4'd9, 0, 1, 1, 1);  // lost+gained at max
        vecs[18] = mk(1, 0, 0, 0, 4'd3, 0, 0, 1, 0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].sg, vecs[i].ll, vecs[i].lg, vecs[i].sof);
            chk_all($sformatf("vec%0d", i), vecs[i].lives, vecs[i].go, vecs[i].gr,
                    vecs[i].resp, vecs[i].blink);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("vec18.respOneCycle", int'(respawnReq), 0);

        // Loss from 3, full 90-frame grace with an ignored loss at frame 10
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        chk_all("loss1", 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        run_grace("g1", 90, 10, 4'd2);

        // Down to game over
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("loss2", 4'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        run_grace("g2", 90, 0, 4'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("loss3", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk_all("over.gain", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("over.lost", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("over.start", 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("over.after", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset at frame 40 of grace
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("loss4", 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        run_grace("g3", 40, 0, 4'd2);
        resetN = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        chk_all("midReset", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        resetN = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("postReset.idle", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Grace timer restarts cleanly after reset
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("loss5", 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        run_grace("g4", 90, 0, 4'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
